// File: rtl/rv_regfile_pkg.sv
// rv_regfile_pkg: shared register-file widths and the write-back request struct
package rv_regfile_pkg;
  localparam int REG_AW = 5;
  localparam int XLEN = 32;
  localparam logic [REG_AW-1:0] X0 = 5'd0;
  typedef struct packed {
    logic valid;
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at i_ptr, one-hot grant plus index
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IDW = 2
) (
  input  logic [IDW-1:0]  i_ptr,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);
  // walk offsets from farthest to nearest so the nearest requester after ptr wins
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (i_req[(int'(i_ptr) + k) % NREQ]) begin
        o_any = 1'b1;
        o_idx = IDW'((int'(i_ptr) + k) % NREQ);
      end
  end
  assign o_gnt = o_any ? NREQ'(1) << o_idx : '0;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register-file write port with one-cycle registered write and read forwarding
import rv_regfile_pkg::*;
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int IDW = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [REG_AW*NREQ-1:0] req_addr,
  input  logic [XLEN*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   we,
  output logic [REG_AW-1:0]      add_d,
  output logic [XLEN-1:0]        data_d,
  output logic [IDW-1:0]         grant_id,
  input  logic [REG_AW-1:0]      add_a,
  input  logic [REG_AW-1:0]      add_b,
  output logic                   fwd_a_hit,
  output logic                   fwd_b_hit,
  output logic [XLEN-1:0]        fwd_data
);
  wb_req_t           w_req [NREQ];
  wb_req_t           w_win;
  logic [NREQ-1:0]   w_act;
  logic [NREQ-1:0]   w_gnt;
  logic [IDW-1:0]    w_idx;
  logic              w_xfer;
  logic              r_we;
  logic [REG_AW-1:0] r_add_d;
  logic [XLEN-1:0]   r_data_d;
  logic [IDW-1:0]    r_grant_id;
  logic [IDW-1:0]    r_ptr;

  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign w_req[i] = '{valid: req_valid[i], addr: req_addr[REG_AW*i +: REG_AW], data: req_data[XLEN*i +: XLEN]};
    assign w_act[i] = w_req[i].valid & rst & ~hold;
  end

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .i_ptr(r_ptr),
    .i_req(w_act),
    .o_gnt(w_gnt),
    .o_idx(w_idx),
    .o_any(w_xfer)
  );

  assign w_win = w_req[w_idx];
  assign req_ready = w_gnt;

  // register the accepted write; x0 is consumed but never raises we
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we <= 1'b0;
      r_add_d <= '0;
      r_data_d <= '0;
      r_grant_id <= '0;
      r_ptr <= '0;
    end else begin
      r_we <= w_xfer && (w_win.addr != X0);
      if (w_xfer) begin
        r_add_d <= w_win.addr;
        r_data_d <= w_win.data;
        r_grant_id <= w_idx;
        r_ptr <= (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
      end
    end
  end

  assign we = r_we;
  assign add_d = r_add_d;
  assign data_d = r_data_d;
  assign grant_id = r_grant_id;
  assign fwd_data = r_data_d;
  assign fwd_a_hit = r_we && (r_add_d == add_a) && (add_a != X0);
  assign fwd_b_hit = r_we && (r_add_d == add_b) && (add_b != X0);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenarios with literal expectations plus randomized traffic against a behavioural model
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst, hold;
  logic [NREQ-1:0] req_valid;
  logic [5*NREQ-1:0] req_addr;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic we, fwd_a_hit, fwd_b_hit;
  logic [4:0] add_d, add_a, add_b;
  logic [31:0] data_d, fwd_data;
  logic [IDW-1:0] grant_id;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  regfile_wb_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .hold(hold), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .we(we), .add_d(add_d), .data_d(data_d),
    .grant_id(grant_id), .add_a(add_a), .add_b(add_b), .fwd_a_hit(fwd_a_hit),
    .fwd_b_hit(fwd_b_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic int win(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // behavioural model: what the write port must show after each edge
  logic m_we = 1'b0;
  logic [4:0] m_ad = '0;
  logic [31:0] m_dd = '0;
  int m_gid = 0;
  int m_ptr = 0;
  int m_w;
  assign m_w = win(req_valid, m_ptr);

  always @(posedge clk) begin
    if (!rst) begin
      m_we <= 1'b0;
      m_ad <= '0;
      m_dd <= '0;
      m_gid <= 0;
      m_ptr <= 0;
    end else if (!hold && m_w >= 0) begin
      m_we <= req_addr[m_w*5 +: 5] != 5'd0;
      m_ad <= req_addr[m_w*5 +: 5];
      m_dd <= req_data[m_w*32 +: 32];
      m_gid <= m_w;
      m_ptr <= (m_w + 1) % NREQ;
    end else begin
      m_we <= 1'b0;
    end
  end

  // compare every cycle once the model has seen a reset edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), (rst && !hold && m_w >= 0) ? 32'(1) << m_w : 32'd0);
      chk("we", 32'(we), 32'(m_we));
      chk("add_d", 32'(add_d), 32'(m_ad));
      chk("data_d", data_d, m_dd);
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      chk("fwd_a_hit", 32'(fwd_a_hit), 32'(m_we && m_ad == add_a && add_a != 0));
      chk("fwd_b_hit", 32'(fwd_b_hit), 32'(m_we && m_ad == add_b && add_b != 0));
      chk("fwd_data", fwd_data, m_dd);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_addr[i*5 +: 5] = a;
    req_data[i*32 +: 32] = d;
  endtask

  initial begin
    rst = 1'b0; hold = 1'b0; req_valid = 3'b111; add_a = '0; add_b = '0;
    set_req(0, 5'd1, 32'h1111_0001);
    set_req(1, 5'd2, 32'h2222_0002);
    set_req(2, 5'd3, 32'h3333_0003);
    step();
    chk_en = 1'b1;
    look();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    step();
    look();
    chk("rst_add_d", 32'(add_d), 32'd0);
    chk("rst_data_d", data_d, 32'd0);
    // round robin with all three valid
    step();
    rst = 1'b1;
    look();
    chk("rr_ready0", 32'(req_ready), 32'b001);
    step(); look();
    chk("rr_add1", 32'(add_d), 32'd1); chk("rr_gid0", 32'(grant_id), 32'd0); chk("rr_ready1", 32'(req_ready), 32'b010);
    step(); look();
    chk("rr_add2", 32'(add_d), 32'd2); chk("rr_gid1", 32'(grant_id), 32'd1); chk("rr_ready2", 32'(req_ready), 32'b100);
    step(); look();
    chk("rr_add3", 32'(add_d), 32'd3); chk("rr_gid2", 32'(grant_id), 32'd2); chk("rr_we3", 32'(we), 32'd1);
    step();
    req_valid = 3'b001;
    set_req(0, 5'd5, 32'hDEAD_BEEF);
    look();
    chk("rr_add4", 32'(add_d), 32'd1); chk("rr_gid3", 32'(grant_id), 32'd0);
    chk("single_ready", 32'(req_ready), 32'b001);
    step();
    req_valid = 3'b000;
    look();
    chk("single_we", 32'(we), 32'd1); chk("single_add", 32'(add_d), 32'd5);
    chk("single_data", data_d, 32'hDEAD_BEEF); chk("single_gid", 32'(grant_id), 32'd0);
    step(); look();
    chk("single_we_off", 32'(we), 32'd0);
    // x0 write is consumed without we, pointer moves to 2
    req_valid = 3'b010;
    set_req(1, 5'd0, 32'h1234_5678);
    look();
    chk("x0_ready", 32'(req_ready), 32'b010);
    step();
    req_valid = 3'b111;
    set_req(0, 5'd6, 32'h6);
    set_req(1, 5'd4, 32'h1);
    set_req(2, 5'd8, 32'h8);
    look();
    chk("x0_we", 32'(we), 32'd0); chk("x0_gid", 32'(grant_id), 32'd1);
    chk("x0_next_ready", 32'(req_ready), 32'b100);
    step();
    req_valid = 3'b000;
    step();
    // hold blocks acceptance without dropping the request
    hold = 1'b1; req_valid = 3'b100;
    set_req(2, 5'd7, 32'h7777_7777);
    for (int i = 0; i < 3; i++) begin
      look();
      chk("hold_ready", 32'(req_ready), 32'd0);
      step();
      chk("hold_we", 32'(we), 32'd0);
    end
    hold = 1'b0;
    look();
    chk("unhold_ready", 32'(req_ready), 32'b100);
    step();
    req_valid = 3'b000;
    look();
    chk("unhold_we", 32'(we), 32'd1); chk("unhold_add", 32'(add_d), 32'd7);
    // forwarding
    req_valid = 3'b001;
    set_req(0, 5'd9, 32'hCAFE_F00D);
    add_a = 5'd9; add_b = 5'd0;
    step();
    req_valid = 3'b000;
    look();
    chk("fwd_a", 32'(fwd_a_hit), 32'd1); chk("fwd_b", 32'(fwd_b_hit), 32'd0);
    chk("fwd_data_lit", fwd_data, 32'hCAFE_F00D);
    step(); look();
    chk("fwd_a_off", 32'(fwd_a_hit), 32'd0); chk("fwd_b_off", 32'(fwd_b_hit), 32'd0);
    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      hold = ($urandom_range(0, 99) < 15);
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        set_req(i, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom);
      add_a = ($urandom_range(0, 1) == 1) ? add_d : 5'($urandom);
      add_b = ($urandom_range(0, 3) == 0) ? 5'd0 : (($urandom_range(0, 1) == 1) ? add_d : 5'($urandom));
    end
    step();
    rst = 1'b1; hold = 1'b0; req_valid = 3'b111;
    repeat (6) step();
    look();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
